// File: rtl/MIDI.sv
// Shared MIDI types and constants for the note parser and its consumers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package MIDI;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } note_status_t;

    typedef struct packed {
        note_status_t status;
        logic [6:0]   note_number;
        logic [6:0]   velocity;
    } note_change_t;

    // Channel voice status nibbles
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CONTROL  = 4'hB;
    localparam logic [3:0] PROGRAM  = 4'hC;
    localparam logic [3:0] PRESSURE = 4'hD;

    // Controllers that silence whatever is sounding
    localparam logic [6:0] ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational decode of one MIDI byte into class and expected data length.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; decodes whatever byte is presented.
module midi_byte_classifier
    import MIDI::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_realtime,
    output logic       is_status,
    output logic       is_data,
    output logic [1:0] data_len
);

    // Class flags plus the number of data bytes a status byte introduces
    always_comb begin
        is_data     = ~rx_byte[7];
        is_realtime = (rx_byte[7:3] == 5'b11111);
        is_status   = rx_byte[7] & ~is_realtime;
        data_len    = 2'd0;
        if (is_status) begin
            if (rx_byte[7:4] != 4'hF) begin
                data_len = ((rx_byte[7:4] == PROGRAM) || (rx_byte[7:4] == PRESSURE)) ? 2'd1 : 2'd2;
            end else begin
                unique case (rx_byte[3:0])
                    4'h1, 4'h3: data_len = 2'd1;
                    4'h2:       data_len = 2'd2;
                    default:    data_len = 2'd0;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte stream to monophonic note on/off events with running status and last-note priority.
// Latency: 1 cycle from the completing rx_valid byte to note_ready / error.
// Backpressure: none; accepts a byte every cycle, events are single-cycle strobes.
module midi_note_parser
    import MIDI::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned OMNI    = 0,
    parameter int unsigned NOTE_LO = 21,
    parameter int unsigned NOTE_HI = 108
)(
    input  logic         clock_50_000_000,
    input  logic         reset,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    output note_change_t note,
    output logic         note_ready,
    output logic         error
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP_SYSEX} state_t;

    state_t       state_q, state_d;
    logic [7:0]   rs_q, rs_d;
    logic [6:0]   d1_q, d1_d;
    logic         two_q, two_d;
    logic [6:0]   held_q, held_d;
    logic         held_valid_q, held_valid_d;
    note_change_t note_q, note_d;
    logic         note_ready_q, note_ready_d;
    logic         error_q, error_d;

    logic       is_realtime, is_status, is_data;
    logic [1:0] data_len;
    logic       complete;
    logic       chan_match;
    logic       in_range;
    logic [6:0] vel;

    midi_byte_classifier u_classifier (
        .rx_byte     (rx_byte),
        .is_realtime (is_realtime),
        .is_status   (is_status),
        .is_data     (is_data),
        .data_len    (data_len)
    );

    assign vel        = rx_byte[6:0];
    assign chan_match = (OMNI != 0) || (rs_q[3:0] == 4'(CHANNEL));
    assign in_range   = (32'(d1_q) >= NOTE_LO) && (32'(d1_q) <= NOTE_HI);

    // Next-state, message assembly and event generation for one received byte
    always_comb begin
        state_d      = state_q;
        rs_d         = rs_q;
        d1_d         = d1_q;
        two_d        = two_q;
        held_d       = held_q;
        held_valid_d = held_valid_q;
        note_d       = note_q;
        note_ready_d = 1'b0;
        error_d      = 1'b0;
        complete     = 1'b0;

        if (rx_valid && !is_realtime) begin
            if (is_status) begin
                // System common messages reuse the data-collection states with rs
                // cleared; rs[7]==0 then marks the collected bytes as discarded.
                two_d = (data_len == 2'd2);
                if (rx_byte[7:4] != 4'hF) begin
                    rs_d    = rx_byte;
                    state_d = WAIT_D1;
                end else begin
                    rs_d = '0;
                    if (rx_byte == 8'hF0)
                        state_d = SKIP_SYSEX;
                    else if (data_len != 2'd0)
                        state_d = WAIT_D1;
                    else
                        state_d = IDLE;
                end
            end else if (is_data) begin
                unique case (state_q)
                    IDLE:    error_d = 1'b1;
                    WAIT_D1: begin
                        if (two_q) begin
                            d1_d    = rx_byte[6:0];
                            state_d = WAIT_D2;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    WAIT_D2: complete = 1'b1;
                    default: ;
                endcase
            end
        end

        if (complete) begin
            state_d = rs_q[7] ? WAIT_D1 : IDLE;
            // Only two-byte messages can produce events, so d1_q is always valid here
            if (rs_q[7] && chan_match) begin
                case (rs_q[7:4])
                    NOTE_ON, NOTE_OFF: begin
                        if ((rs_q[7:4] == NOTE_ON) && (vel != 7'd0)) begin
                            if (in_range) begin
                                note_d       = '{status: ON, note_number: d1_q, velocity: vel};
                                note_ready_d = 1'b1;
                                held_d       = d1_q;
                                held_valid_d = 1'b1;
                            end
                        end else if (held_valid_q && (d1_q == held_q)) begin
                            note_d       = '{status: OFF, note_number: d1_q, velocity: vel};
                            note_ready_d = 1'b1;
                            held_valid_d = 1'b0;
                        end
                    end
                    CONTROL: begin
                        if (held_valid_q && ((d1_q == ALL_SOUND_OFF) || (d1_q == ALL_NOTES_OFF))) begin
                            note_d       = '{status: OFF, note_number: held_q, velocity: 7'd0};
                            note_ready_d = 1'b1;
                            held_valid_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rs_q         <= '0;
            d1_q         <= '0;
            two_q        <= 1'b0;
            held_q       <= '0;
            held_valid_q <= 1'b0;
            note_q       <= '{status: OFF, note_number: 7'd0, velocity: 7'd0};
            note_ready_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            d1_q         <= d1_d;
            two_q        <= two_d;
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            note_q       <= note_d;
            note_ready_q <= note_ready_d;
            error_q      <= error_d;
        end
    end

    assign note       = note_q;
    assign note_ready = note_ready_q;
    assign error      = error_q;

endmodule
